// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants for the BCD display scanner: position count and
// active-low segment patterns ({g,f,e,d,c,b,a}).
package bcd_display_scanner_pkg;

   localparam int NUM_POS  = 6;
   localparam int SIGN_POS = NUM_POS - 1;

   localparam logic [6:0] SEG_DARK  = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Value/strobe inputs and multiplexed display drive of the scanner.
interface bcd_display_scanner_if;
   import bcd_display_scanner_pkg::*;

   logic [19:0]        bcd_in;
   logic               neg_in;
   logic               load;
   logic               blank;
   logic [NUM_POS-1:0] an;
   logic [6:0]         seg;

   modport master (output bcd_in, neg_in, load, blank, input an, seg);
   modport slave  (input bcd_in, neg_in, load, blank, output an, seg);

endinterface

// File: rtl/bcd_display_scanner_bcd_to_seg.sv
// One BCD digit to active-low seven-segment pattern; digits above 9 show 'E'.
module bcd_to_seg
   import bcd_display_scanner_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       dark,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DARK;
      if (!dark) begin
         case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
         endcase
      end
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Six-position common-anode scanner: snapshots five BCD digits plus sign,
// blanks leading zeros and inserts an all-off guard cycle before each move.
module bcd_display_scanner
   import bcd_display_scanner_pkg::*;
#(
   parameter int PRESCALE = 50000,
   parameter int CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   bcd_display_scanner_if.slave disp
);

   localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(PRESCALE - 1);
   localparam bit               GUARD_EN = (PRESCALE >= 2);

   logic [19:0]        snap;
   logic               snap_neg;
   logic [CNT_W-1:0]   remain;
   logic [2:0]         idx;
   logic [NUM_POS-1:0] an_q;
   logic [6:0]         seg_q;

   logic               tc;
   logic [4:0]         nz;
   logic [3:0]         digit;
   logic               digit_dark;
   logic [6:0]         digit_seg;
   logic [NUM_POS-1:0] an_next;
   logic [6:0]         seg_next;

   // remain counts cycles left at the current position; tc is its last cycle
   assign tc = (remain == '0);

   // nz[k]: some snapshot digit at position k or above is non-zero
   always_comb begin
      nz    = '0;
      nz[4] = (snap[19:16] != 4'd0);
      nz[3] = nz[4] | (snap[15:12] != 4'd0);
      nz[2] = nz[3] | (snap[11:8]  != 4'd0);
      nz[1] = nz[2] | (snap[7:4]   != 4'd0);
      nz[0] = nz[1] | (snap[3:0]   != 4'd0);
   end

   always_comb begin
      digit      = 4'd0;
      digit_dark = 1'b1;
      case (idx)
         3'd0: begin digit = snap[3:0];   digit_dark = 1'b0;   end
         3'd1: begin digit = snap[7:4];   digit_dark = ~nz[1]; end
         3'd2: begin digit = snap[11:8];  digit_dark = ~nz[2]; end
         3'd3: begin digit = snap[15:12]; digit_dark = ~nz[3]; end
         3'd4: begin digit = snap[19:16]; digit_dark = ~nz[4]; end
         default: ;
      endcase
   end

   bcd_to_seg u_bcd_to_seg (
      .digit (digit),
      .dark  (digit_dark),
      .seg   (digit_seg)
   );

   // Out-of-range idx shifts the one-cold pattern off the end, leaving all anodes off
   always_comb begin
      an_next  = ~(NUM_POS'(1) << idx);
      seg_next = digit_seg;
      if (idx == 3'(SIGN_POS))
         seg_next = (snap_neg && nz[0]) ? SEG_MINUS : SEG_DARK;
      if (disp.blank || (GUARD_EN && tc)) begin
         an_next  = '1;
         seg_next = SEG_DARK;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap     <= '0;
         snap_neg <= 1'b0;
         remain   <= RELOAD;
         idx      <= '0;
         an_q     <= '1;
         seg_q    <= SEG_DARK;
      end else begin
         if (disp.load) begin
            snap     <= disp.bcd_in;
            snap_neg <= disp.neg_in;
         end
         remain <= tc ? RELOAD : remain - CNT_W'(1);
         if (idx > 3'(SIGN_POS))
            idx <= '0;
         else if (tc)
            idx <= (idx == 3'(SIGN_POS)) ? 3'd0 : idx + 3'd1;
         an_q  <= an_next;
         seg_q <= seg_next;
      end
   end

   assign disp.an  = an_q;
   assign disp.seg = seg_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: stimulus pushes the expected an/seg for every clock edge,
// a monitor pops and compares one entry per edge.
module tb_bcd_display_scanner;

   localparam int PRESCALE = 4;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SE = 7'b0000110;
   localparam logic [6:0] DK = 7'b1111111;
   localparam logic [6:0] MN = 7'b0111111;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   bcd_display_scanner_if disp();

   bcd_display_scanner #(.PRESCALE(PRESCALE), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .disp  (disp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] an;
      logic [6:0] seg;
      string      tag;
   } exp_t;

   exp_t       exp_q[$];
   int         checks   = 0;
   int         failures = 0;
   int         c        = 0;
   logic [6:0] shown[6];
   logic [6:0] pending[6];
   string      tag = "reset";

   // Expected output for the coming edge, from the bench's own scan timeline
   task automatic tick();
      exp_t e;
      int   pos;
      e.tag = tag;
      if (!reset) begin
         e.an  = 6'b111111;
         e.seg = DK;
      end else begin
         pos = (c / PRESCALE) % 6;
         if (disp.blank || (c % PRESCALE) == PRESCALE - 1) begin
            e.an  = 6'b111111;
            e.seg = DK;
         end else begin
            e.an  = ~(6'b000001 << pos);
            e.seg = shown[pos];
         end
         c++;
      end
      exp_q.push_back(e);
      @(negedge clk);
      if (!reset) begin
         c     = 0;
         shown = '{S0, DK, DK, DK, DK, DK};
      end else if (disp.load) begin
         shown = pending;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load_val(input logic [19:0] v, input logic n, input string t,
                           input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                           input logic [6:0] p3, input logic [6:0] p4, input logic [6:0] p5);
      tag         = t;
      disp.bcd_in = v;
      disp.neg_in = n;
      pending     = '{p0, p1, p2, p3, p4, p5};
      disp.load   = 1'b1;
      tick();
      disp.load   = 1'b0;
      disp.bcd_in = 20'h0;
      disp.neg_in = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (disp.an !== e.an || disp.seg !== e.seg) begin
               failures++;
               $display("FAIL %s: got an=%b seg=%b, expected an=%b seg=%b",
                        e.tag, disp.an, disp.seg, e.an, e.seg);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      failures++;
      $display("FAIL watchdog: stimulus did not complete within time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : stimulus
      disp.bcd_in = 20'h0;
      disp.neg_in = 1'b0;
      disp.load   = 1'b0;
      disp.blank  = 1'b0;
      shown       = '{S0, DK, DK, DK, DK, DK};

      run(3);
      reset = 1'b1;
      tag   = "idle";
      run(26);

      load_val(20'h01234, 1'b1, "neg_1234", S4, S3, S2, S1, DK, MN);
      run(24);
      load_val(20'h00000, 1'b1, "neg_zero", S0, DK, DK, DK, DK, DK);
      run(24);
      load_val(20'h0A005, 1'b0, "invalid_digit", S5, S0, S0, SE, DK, DK);
      run(24);
      load_val(20'h90000, 1'b1, "neg_90000", S0, S0, S0, S0, S9, MN);
      run(24);

      // capture on the same edge that advances the position
      tag = "align";
      while ((c % PRESCALE) != PRESCALE - 1) tick();
      load_val(20'h56789, 1'b0, "load_at_advance", S9, S8, S7, S6, S5, DK);
      run(24);

      tag        = "blank";
      disp.blank = 1'b1;
      run(5);
      disp.blank = 1'b0;
      tag        = "after_blank";
      run(24);

      tag = "seek_pos2";
      while (!(((c / PRESCALE) % 6) == 2 && (c % PRESCALE) == 1)) tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (disp.an !== 6'b111111 || disp.seg !== DK) begin
         failures++;
         $display("FAIL async_reset: got an=%b seg=%b, expected an=%b seg=%b",
                  disp.an, disp.seg, 6'b111111, DK);
      end
      tag = "reset_mid";
      run(3);
      reset = 1'b1;
      tag   = "after_reset";
      run(26);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
